// File: rtl/time_dmr_retry_sched.sv
// Retry scheduler in front of time_DMR_start (external-ID mode).
// Tags each new transaction with a rotating ID, keeps a copy per ID until the
// end side reports completion, re-issues copies on retry requests (retries win
// over new traffic) and drops an ID once its retry budget is spent.
// Optional build macro TIME_DMR_RETRY_SCHED_STATS_EN adds retry/drop counters.
module time_dmr_retry_sched #(
  parameter type         DataType   = logic [7:0],
  parameter int unsigned IDSize     = 4,
  parameter int unsigned MaxRetries = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              done_valid_i,
  input  logic [IDSize-1:0] done_id_i,
  input  logic              retry_valid_i,
  input  logic [IDSize-1:0] retry_id_i,
`ifdef TIME_DMR_RETRY_SCHED_STATS_EN
  output logic [15:0]       retry_cnt_o,
  output logic [15:0]       drop_cnt_o,
`endif
  output logic              error_o,
  output logic [IDSize-1:0] error_id_o,
  output logic              busy_o
);

  localparam int unsigned Depth = 2 ** IDSize;
  localparam int unsigned CntW  = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxRetries);

  logic [Depth-1:0]  alloc_q, alloc_d, pend_q, pend_d;
  logic [CntW-1:0]   cnt_q [Depth];
  logic [CntW-1:0]   cnt_d [Depth];
  DataType           tbl_q [Depth];
  logic [IDSize-1:0] next_id_q, next_id_d;
  logic              mode_q, mode_d;  // 1: scheduling, 0: bypass
  logic              valid_q, valid_d;
  DataType           dout_q, dout_d;
  logic [IDSize-1:0] id_q, id_d;
  logic              err_q, err_d;
  logic [IDSize-1:0] err_id_q, err_id_d;
  logic              busy_q;

  logic              slot_free, mode_switch, ready;
  logic              pend_found, accept, issue_retry, drop;
  logic [IDSize-1:0] pend_idx;

  assign slot_free   = !valid_q || ready_i;
  // Mode only changes once nothing is in flight and the output stage is empty.
  assign mode_switch = !busy_q && !valid_q && (enable_i != mode_q);
  assign mode_d      = mode_switch ? enable_i : mode_q;

  // Lowest-index pending entry has issue priority.
  always_comb begin
    pend_found = 1'b0;
    pend_idx   = '0;
    for (int i = 0; i < Depth; i++) begin
      if (pend_q[i] && !pend_found) begin
        pend_found = 1'b1;
        pend_idx   = IDSize'(i);
      end
    end
  end

  // Upstream ready; held low during a mode switch so nothing is accepted under
  // the outgoing mode's bookkeeping.
  always_comb begin
    if (mode_switch) begin
      ready = 1'b0;
    end else if (mode_q) begin
      ready = slot_free && !alloc_q[next_id_q] && !pend_found;
    end else begin
      ready = slot_free;
    end
  end

  assign ready_o = ready;

  // Next-state for output stage and ID table: issue first, then done, then retry.
  always_comb begin
    alloc_d     = alloc_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    next_id_d   = next_id_q;
    valid_d     = valid_q;
    dout_d      = dout_q;
    id_d        = id_q;
    err_d       = 1'b0;
    err_id_d    = err_id_q;
    accept      = 1'b0;
    issue_retry = 1'b0;
    drop        = 1'b0;

    if (slot_free) begin
      valid_d = 1'b0;
      if (mode_q) begin
        if (pend_found) begin
          issue_retry       = 1'b1;
          valid_d           = 1'b1;
          dout_d            = tbl_q[pend_idx];
          id_d              = pend_idx;
          pend_d[pend_idx]  = 1'b0;
          cnt_d[pend_idx]   = cnt_q[pend_idx] + CntW'(1);
        end else if (valid_i && ready) begin
          accept             = 1'b1;
          valid_d            = 1'b1;
          dout_d             = data_i;
          id_d               = next_id_q;
          alloc_d[next_id_q] = 1'b1;
          pend_d[next_id_q]  = 1'b0;
          cnt_d[next_id_q]   = '0;
          next_id_d          = next_id_q + IDSize'(1);
        end
      end else if (valid_i && ready) begin
        valid_d = 1'b1;
        dout_d  = data_i;
        id_d    = '0;
      end
    end

    if (mode_q) begin
      // A same-cycle retry on the same ID overrides the completion.
      if (done_valid_i && alloc_q[done_id_i] &&
          !(retry_valid_i && (retry_id_i == done_id_i))) begin
        alloc_d[done_id_i] = 1'b0;
        pend_d[done_id_i]  = 1'b0;
        cnt_d[done_id_i]   = '0;
      end
      // Budget is judged on the count after any load made this cycle.
      if (retry_valid_i && alloc_q[retry_id_i]) begin
        if (cnt_d[retry_id_i] < MaxCnt) begin
          pend_d[retry_id_i] = 1'b1;
        end else begin
          drop                = 1'b1;
          alloc_d[retry_id_i] = 1'b0;
          pend_d[retry_id_i]  = 1'b0;
          cnt_d[retry_id_i]   = '0;
          err_d               = 1'b1;
          err_id_d            = retry_id_i;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q   <= '0;
      pend_q    <= '0;
      for (int i = 0; i < Depth; i++) cnt_q[i] <= '0;
      next_id_q <= '0;
      mode_q    <= 1'b1;
      valid_q   <= 1'b0;
      dout_q    <= '0;
      id_q      <= '0;
      err_q     <= 1'b0;
      err_id_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      alloc_q   <= alloc_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      next_id_q <= next_id_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
      id_q      <= id_d;
      err_q     <= err_d;
      err_id_q  <= err_id_d;
      busy_q    <= |alloc_d;
    end
  end

  // Payload copies; only meaningful while alloc is set, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (accept) tbl_q[next_id_q] <= data_i;
  end

  assign valid_o    = valid_q;
  assign data_o     = dout_q;
  assign id_o       = id_q;
  assign error_o    = err_q;
  assign error_id_o = err_id_q;
  assign busy_o     = busy_q;

`ifdef TIME_DMR_RETRY_SCHED_STATS_EN
  logic [15:0] retry_cnt_q, drop_cnt_q;

  // Saturating retry-issue and drop counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retry_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (issue_retry && (retry_cnt_q != 16'hFFFF)) retry_cnt_q <= retry_cnt_q + 16'd1;
      if (drop && (drop_cnt_q != 16'hFFFF))         drop_cnt_q  <= drop_cnt_q + 16'd1;
    end
  end

  assign retry_cnt_o = retry_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule
